// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the 5-stage RISC pipeline hazard controller.
// Holds register-file geometry, the no-op encoding, the opcode numbers of the
// instructions the controller cares about, and the multiplier sequencer states.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned REG_IDX_W = 4;

    // Encoding injected into the OF/EX latch for a bubble (opcode 13 = nop)
    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    // Opcode field values, instr[31:27]
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the operand-fetch, branch-resolve and writeback signals seen by the
// hazard controller, plus the pipeline control lines it returns.
//   master : pipeline side (drives OF/EX/RW info, receives stall/flush/issue)
//   slave  : hazard controller
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic                 of_valid;
    logic [REG_IDX_W-1:0] of_rs1;
    logic                 of_rs1_used;
    logic [REG_IDX_W-1:0] of_rs2;
    logic                 of_rs2_used;
    logic [REG_IDX_W-1:0] of_rd;
    logic                 of_wb;
    logic                 of_is_mul;
    logic                 of_is_ld;
    logic                 ex_branch_taken;
    logic                 rw_valid;
    logic [REG_IDX_W-1:0] rw_rd;

    logic                 stall_if;
    logic                 stall_of;
    logic                 bubble_ex;
    logic                 flush;
    logic                 issue;
    logic                 mul_start;
    logic                 mul_busy;

    modport master (
        output of_valid, of_rs1, of_rs1_used, of_rs2, of_rs2_used, of_rd, of_wb,
               of_is_mul, of_is_ld, ex_branch_taken, rw_valid, rw_rd,
        input  stall_if, stall_of, bubble_ex, flush, issue, mul_start, mul_busy
    );

    modport slave (
        input  of_valid, of_rs1, of_rs1_used, of_rs2, of_rs2_used, of_rd, of_wb,
               of_is_mul, of_is_ld, ex_branch_taken, rw_valid, rw_rd,
        output stall_if, stall_of, bubble_ex, flush, issue, mul_start, mul_busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write counters.
//   clk, reset (sync, active-low)   : clock / clear all counters
//   inc_en/inc_idx                  : an issued instruction will write inc_idx
//   dec_en/dec_idx                  : RW stage wrote dec_idx this cycle
//   rs1_idx/rs2_idx -> rs1/rs2_pend : source has an outstanding write
//                                     (only built without FORWARDING_EN)
//   rd_idx -> rd_full               : destination counter is saturated
module reg_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec_en,
    input  logic [REG_IDX_W-1:0] dec_idx,
`ifndef FORWARDING_EN
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic                 rs1_pend,
    output logic                 rs2_pend,
`endif
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic                 rd_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // Inc and dec of the same register cancel; inc saturates, dec clamps at 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_en && inc_idx == REG_IDX_W'(i) &&
                    !(dec_en && dec_idx == REG_IDX_W'(i))) begin
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec_en && dec_idx == REG_IDX_W'(i) &&
                             !(inc_en && inc_idx == REG_IDX_W'(i))) begin
                    if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

`ifndef FORWARDING_EN
    assign rs1_pend = (cnt[rs1_idx] != '0);
    assign rs2_pend = (cnt[rs2_idx] != '0);
`endif
    assign rd_full  = (cnt[rd_idx] == CNT_MAX);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock / sequencing controller beside the OF stage: stalls IF/OF on RAW
// hazards (scoreboard), sequences the multi-cycle multiplier and flushes IF/OF
// after taken branches. Outputs are combinational from state plus inputs and
// are forced low while reset is asserted.
//   clk, reset (sync, active-low)
//   bus (slave) : OF instruction info, branch-taken, RW writeback in;
//                 stall_if/stall_of/bubble_ex/flush/issue/mul_start/mul_busy out
// Build option FORWARDING_EN: bypass network present, only load-use interlocks.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MUL_LAT      = 3,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned MC_W = 3;
    localparam int unsigned FL_W = 2;

    mul_state_e       state_q, state_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic [FL_W-1:0]  fcnt_q;
    logic             mul_start_c;
    logic             flush_c, busy_c, src_haz_c, hazard_c, stall_c, issue_c;
    logic             rd_full;

`ifdef FORWARDING_EN
    logic                 ld_q;
    logic [REG_IDX_W-1:0] ld_rd_q;

    // Only a load issued last cycle can't be bypassed in time
    assign src_haz_c = ld_q && ((bus.of_rs1_used && bus.of_rs1 == ld_rd_q) ||
                                (bus.of_rs2_used && bus.of_rs2 == ld_rd_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_q    <= 1'b0;
            ld_rd_q <= '0;
        end else begin
            ld_q    <= issue_c && bus.of_is_ld && bus.of_wb;
            ld_rd_q <= bus.of_rd;
        end
    end
`else
    logic rs1_pend, rs2_pend;

    assign src_haz_c = (bus.of_rs1_used && rs1_pend) || (bus.of_rs2_used && rs2_pend);
`endif

    reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (issue_c && bus.of_wb),
        .inc_idx  (bus.of_rd),
        .dec_en   (bus.rw_valid),
        .dec_idx  (bus.rw_rd),
`ifndef FORWARDING_EN
        .rs1_idx  (bus.of_rs1),
        .rs2_idx  (bus.of_rs2),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
`endif
        .rd_idx   (bus.of_rd),
        .rd_full  (rd_full)
    );

    // Hazard/stall/issue decode; a saturated destination counter also holds issue
    always_comb begin
        flush_c  = bus.ex_branch_taken || (fcnt_q != '0);
        busy_c   = (state_q == MUL_BUSY);
        hazard_c = bus.of_valid && (src_haz_c || (bus.of_wb && rd_full));
        stall_c  = hazard_c || busy_c;
        issue_c  = reset && bus.of_valid && !stall_c && !flush_c;
    end

    // Multiplier sequencer next-state
    always_comb begin
        state_d     = state_q;
        mcnt_d      = mcnt_q;
        mul_start_c = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (issue_c && bus.of_is_mul) begin
                    mul_start_c = 1'b1;
                    mcnt_d      = MC_W'(MUL_LAT - 1);
                    state_d     = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mcnt_q == '0) state_d = MUL_IDLE;
                else              mcnt_d  = mcnt_q - MC_W'(1);
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // State registers; a new taken branch reloads the flush hold counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MUL_IDLE;
            mcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            if (bus.ex_branch_taken)  fcnt_q <= FL_W'(FLUSH_CYCLES - 1);
            else if (fcnt_q != '0)    fcnt_q <= fcnt_q - FL_W'(1);
        end
    end

    // Flush wins over stall
    always_comb begin
        bus.stall_if  = reset && stall_c && !flush_c;
        bus.stall_of  = reset && stall_c && !flush_c;
        bus.bubble_ex = reset && stall_c && !flush_c;
        bus.flush     = reset && flush_c;
        bus.issue     = issue_c;
        bus.mul_start = mul_start_c;
        bus.mul_busy  = reset && busy_c;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level reference
// model built from pending-write counts, remaining multiplier cycles and
// remaining flush cycles.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT      = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_MAX      = 3;
    localparam int NCYC         = 4000;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(
        .CNT_W        (2),
        .MUL_LAT      (MUL_LAT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_cnt [16];
    int m_mul_left;
    int m_flush_left;
    bit m_ld_v;
    int m_ld_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_mul_left   = 0;
        m_flush_left = 0;
        m_ld_v       = 1'b0;
        m_ld_rd      = 0;
    endtask

    initial begin
        int rmax, rwv_pct;
        bit busy, fl, haz, st;
        bit e_stall, e_issue, e_flush, e_start, e_busy;
        int rs1, rs2, rd, rwrd;

        model_clear();
        reset = 1'b0;
        bus.of_valid = 0; bus.of_rs1 = 0; bus.of_rs1_used = 0; bus.of_rs2 = 0;
        bus.of_rs2_used = 0; bus.of_rd = 0; bus.of_wb = 0; bus.of_is_mul = 0;
        bus.of_is_ld = 0; bus.ex_branch_taken = 0; bus.rw_valid = 0; bus.rw_rd = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Epochs alternate narrow/wide register ranges and writeback rates
            rmax    = ((cyc / 500) % 2 == 1) ? 3 : 15;
            rwv_pct = ((cyc / 500) % 3 == 2) ? 5 : 40;

            reset = (cyc < 3 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
            bus.of_valid        = ($urandom_range(99) < 85);
            bus.of_rs1          = 4'($urandom_range(rmax));
            bus.of_rs1_used     = ($urandom_range(99) < 70);
            bus.of_rs2          = 4'($urandom_range(rmax));
            bus.of_rs2_used     = ($urandom_range(99) < 70);
            bus.of_rd           = 4'($urandom_range(rmax));
            bus.of_wb           = ($urandom_range(99) < 70);
            bus.of_is_mul       = ($urandom_range(99) < 10);
            bus.of_is_ld        = !bus.of_is_mul && ($urandom_range(99) < 20);
            bus.ex_branch_taken = ($urandom_range(99) < 5);
            bus.rw_valid        = ($urandom_range(99) < rwv_pct);
            bus.rw_rd           = 4'($urandom_range(rmax));
            #1;

            rs1  = int'(bus.of_rs1);
            rs2  = int'(bus.of_rs2);
            rd   = int'(bus.of_rd);
            rwrd = int'(bus.rw_rd);

            busy = (m_mul_left > 0);
            fl   = bus.ex_branch_taken || (m_flush_left > 0);
`ifdef FORWARDING_EN
            haz = m_ld_v && ((bus.of_rs1_used && rs1 == m_ld_rd) ||
                             (bus.of_rs2_used && rs2 == m_ld_rd));
`else
            haz = (bus.of_rs1_used && m_cnt[rs1] > 0) || (bus.of_rs2_used && m_cnt[rs2] > 0);
`endif
            haz = bus.of_valid && (haz || (bus.of_wb && m_cnt[rd] == CNT_MAX));
            st  = haz || busy;

            if (reset) begin
                e_stall = st && !fl;
                e_issue = bus.of_valid && !st && !fl;
                e_flush = fl;
                e_busy  = busy;
                e_start = e_issue && bus.of_is_mul;
            end else begin
                e_stall = 0; e_issue = 0; e_flush = 0; e_busy = 0; e_start = 0;
            end

            chk("stall_if",  32'(bus.stall_if),  32'(e_stall));
            chk("stall_of",  32'(bus.stall_of),  32'(e_stall));
            chk("bubble_ex", 32'(bus.bubble_ex), 32'(e_stall));
            chk("flush",     32'(bus.flush),     32'(e_flush));
            chk("issue",     32'(bus.issue),     32'(e_issue));
            chk("mul_start", 32'(bus.mul_start), 32'(e_start));
            chk("mul_busy",  32'(bus.mul_busy),  32'(e_busy));

            // Advance the model to what the coming clock edge should produce
            if (!reset) begin
                model_clear();
            end else begin
                if (!(e_issue && bus.of_wb && bus.rw_valid && rd == rwrd)) begin
                    if (e_issue && bus.of_wb && m_cnt[rd] < CNT_MAX) m_cnt[rd]++;
                    if (bus.rw_valid && m_cnt[rwrd] > 0) m_cnt[rwrd]--;
                end
                if (busy)         m_mul_left--;
                else if (e_start) m_mul_left = MUL_LAT;
                if (bus.ex_branch_taken)   m_flush_left = FLUSH_CYCLES - 1;
                else if (m_flush_left > 0) m_flush_left--;
                m_ld_v  = e_issue && bus.of_is_ld && bus.of_wb;
                m_ld_rd = rd;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
